// File: rtl/single_cycle_mips_pkg.sv
// Shared ISA constants, ALU operation encoding and decoded control bundle
// for the single-cycle MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_write;
    logic    branch;
    logic    jump;
    alu_op_t alu_op;
  } ctrl_t;

endpackage

// File: rtl/single_cycle_mips_if.sv
// Register-file access bus: two asynchronous read ports and one write port.
interface mips_rf_if;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;

  modport master (output ra1, ra2, we, wa, wd, input rd1, rd2);
  modport slave  (input ra1, ra2, we, wa, wd, output rd1, rd2);
endinterface

// File: rtl/single_cycle_mips_regfile.sv
// 32x32 register file, cleared by asynchronous reset; $0 always reads zero.
module mips_regfile (
  input  logic     i_clk,
  input  logic     i_rst_n,
  mips_rf_if.slave bus
);

  logic [31:0] regs [32];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.we && (bus.wa != 5'd0)) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  assign bus.rd1 = (bus.ra1 == 5'd0) ? 32'd0 : regs[bus.ra1];
  assign bus.rd2 = (bus.ra2 == 5'd0) ? 32'd0 : regs[bus.ra2];

endmodule

// File: rtl/single_cycle_mips.sv
// Single-cycle 32-bit MIPS subset core: fetch, decode, execute, memory and
// writeback all complete within one i_clk period.
module single_cycle_mips
  import mips_pkg::*;
#(
  parameter int    IMEM_DEPTH     = 256,
  parameter int    DMEM_DEPTH     = 256,
  parameter string IMEM_INIT_FILE = "program.mem"
) (
  input logic i_clk,
  input logic i_rst_n
);

  localparam int IA_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] instr;
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];

  // ---- fetch
  assign instr    = imem[pc[IA_W+1:2]];
  assign pc_plus4 = pc + 32'd4;

  // ---- decode
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [4:0]         rs, rt, rd;
  logic signed [31:0] imm_sext;
  ctrl_t              ctrl;

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          F_ADD:   ctrl.alu_op = ALU_ADD;
          F_SUB:   ctrl.alu_op = ALU_SUB;
          F_AND:   ctrl.alu_op = ALU_AND;
          F_OR:    ctrl.alu_op = ALU_OR;
          F_SLT:   ctrl.alu_op = ALU_SLT;
          default: ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_J:    ctrl.jump = 1'b1;
      default: ;
    endcase
  end

  mips_rf_if rf_bus ();

  mips_regfile rf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (rf_bus.slave)
  );

  assign rf_bus.ra1 = rs;
  assign rf_bus.ra2 = rt;

  // ---- execute
  function automatic logic [31:0] alu_eval(alu_op_t op, logic signed [31:0] a,
                                           logic signed [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'd0, (a < b)};
      default: return 32'd0;
    endcase
  endfunction

  logic signed [31:0] alu_a;
  logic signed [31:0] alu_b;
  logic [31:0]        alu_y;
  logic               br_taken;

  assign alu_a    = rf_bus.rd1;
  assign alu_b    = ctrl.alu_src ? imm_sext : rf_bus.rd2;
  assign alu_y    = alu_eval(ctrl.alu_op, alu_a, alu_b);
  assign br_taken = ctrl.branch && (rf_bus.rd1 == rf_bus.rd2);

  always_comb begin
    pc_next = pc_plus4;
    if (ctrl.jump)    pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (br_taken) pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pc <= '0;
    else          pc <= pc_next;
  end

  // ---- memory (data RAM is never cleared; a store during reset is dropped)
  logic [DA_W-1:0] d_idx;
  logic [31:0]     d_rdata;

  assign d_idx   = alu_y[DA_W+1:2];
  assign d_rdata = dmem[d_idx];

  always_ff @(posedge i_clk) begin
    if (ctrl.mem_write && i_rst_n) dmem[d_idx] <= rf_bus.rd2;
  end

  // ---- writeback
  assign rf_bus.we = ctrl.reg_write;
  assign rf_bus.wa = ctrl.reg_dst ? rd : rt;
  assign rf_bus.wd = ctrl.mem_to_reg ? d_rdata : alu_y;

endmodule

// File: tb/tb_single_cycle_mips.sv
// Directed bench for single_cycle_mips: programs are poked into the ROM and
// architectural state is observed through hierarchical probes.
module tb_single_cycle_mips;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  single_cycle_mips #(
    .IMEM_DEPTH     (256),
    .DMEM_DEPTH     (256),
    .IMEM_INIT_FILE ("")
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          grp;
    string       name;
    int          kind;   // 0 = register, 1 = data word, 2 = pc
    int          idx;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [$];
  logic [31:0] prog [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] f);
    return {OP_RTYPE, rs[4:0], rt[4:0], rd[4:0], 5'd0, f};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] j_ins(int addr);
    return {OP_J, addr[25:0]};
  endfunction

  function automatic logic [31:0] probe(int kind, int idx);
    case (kind)
      0:       return dut.rf.regs[idx];
      1:       return dut.dmem[idx];
      default: return dut.pc;
    endcase
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_table(int grp);
    foreach (vecs[i]) begin
      if (vecs[i].grp == grp)
        check(vecs[i].name, probe(vecs[i].kind, vecs[i].idx), vecs[i].exp);
    end
  endtask

  // Holds reset, replaces the ROM image with prog (rest zero-filled), releases on a negedge.
  task automatic load_and_start();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] regs_or();
    logic [31:0] acc = '0;
    for (int i = 1; i < 32; i++) acc |= dut.rf.regs[i];
    return acc;
  endfunction

  initial begin
    logic [31:0] exp_pc [8];
    int          x_cnt;

    vecs.push_back('{0, "alu_r1_addi",    0, 1, 32'd5});
    vecs.push_back('{0, "alu_r2_addineg", 0, 2, 32'hFFFF_FFFD});
    vecs.push_back('{0, "alu_add",        0, 3, 32'd2});
    vecs.push_back('{0, "alu_sub",        0, 4, 32'd8});
    vecs.push_back('{0, "alu_and",        0, 5, 32'd5});
    vecs.push_back('{0, "alu_or",         0, 6, 32'hFFFF_FFFD});
    vecs.push_back('{0, "alu_slt_true",   0, 7, 32'd1});
    vecs.push_back('{0, "alu_slt_false",  0, 8, 32'd0});
    vecs.push_back('{1, "mem_dmem2",      1, 2, 32'h0000_1234});
    vecs.push_back('{1, "mem_r1",         0, 1, 32'h0000_1234});
    vecs.push_back('{1, "mem_lw_r2",      0, 2, 32'h0000_1234});
    vecs.push_back('{1, "mem_lw_negoff",  0, 3, 32'h0000_1234});
    vecs.push_back('{1, "mem_r4",         0, 4, 32'd16});
    vecs.push_back('{2, "ctl_r0_hard",    0, 0, 32'd0});
    vecs.push_back('{2, "ctl_r1",         0, 1, 32'd1});
    vecs.push_back('{2, "ctl_skip_r9",    0, 9, 32'd0});
    vecs.push_back('{2, "ctl_skip_r10",   0, 10, 32'd0});
    vecs.push_back('{2, "ctl_skip_r11",   0, 11, 32'd0});
    vecs.push_back('{2, "ctl_badfunct",   0, 12, 32'd0});

    // ALU program, also used for reset-behaviour checks
    prog = '{i_ins(OP_ADDI, 0, 1, 5), i_ins(OP_ADDI, 0, 2, -3),
             r_ins(1, 2, 3, F_ADD), r_ins(1, 2, 4, F_SUB), r_ins(1, 2, 5, F_AND),
             r_ins(1, 2, 6, F_OR), r_ins(2, 1, 7, F_SLT), r_ins(1, 2, 8, F_SLT)};
    load_and_start();
    cycles(3);
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    check("rst_async_pc", dut.pc, 32'd0);
    check("rst_async_regs", regs_or(), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_pc", dut.pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_first_pc", dut.pc, 32'd4);
    check("rst_first_r1", dut.rf.regs[1], 32'd5);
    cycles(7);
    run_table(0);

    // Memory program
    prog = '{i_ins(OP_ADDI, 0, 1, 'h1234), i_ins(OP_SW, 0, 1, 8), i_ins(OP_LW, 0, 2, 8),
             i_ins(OP_ADDI, 0, 4, 16), i_ins(OP_LW, 4, 3, -8)};
    load_and_start();
    cycles(5);
    run_table(1);

    // Control flow, $0 write and unknown opcode / funct
    prog = '{};
    for (int i = 0; i < 20; i++) prog.push_back(32'd0);
    prog[0]  = i_ins(OP_BEQ, 0, 0, 2);
    prog[1]  = i_ins(OP_ADDI, 0, 9, 1);
    prog[2]  = i_ins(OP_ADDI, 0, 10, 1);
    prog[3]  = i_ins(OP_ADDI, 0, 1, 1);
    prog[4]  = i_ins(OP_BEQ, 1, 0, 5);
    prog[5]  = j_ins('h10);
    prog[6]  = i_ins(OP_ADDI, 0, 11, 1);
    prog[16] = i_ins(OP_ADDI, 0, 0, 7);
    prog[17] = 32'hFC00_0000;
    prog[18] = {OP_RTYPE, 5'd1, 5'd1, 5'd12, 5'd0, 6'h3F};
    prog[19] = i_ins(OP_BEQ, 0, 0, -1);
    exp_pc = '{32'h0C, 32'h10, 32'h14, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h4C};
    load_and_start();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("ctl_pc_step%0d", k), dut.pc, exp_pc[k]);
    end
    run_table(2);

    // Reset mid-program: data RAM survives, program restarts cleanly
    prog = '{i_ins(OP_ADDI, 0, 1, 'h55), i_ins(OP_SW, 0, 1, 12),
             i_ins(OP_ADDI, 0, 2, 2), i_ins(OP_BEQ, 0, 0, -1)};
    load_and_start();
    cycles(10);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_pc", dut.pc, 32'd0);
    check("mid_rst_regs", regs_or(), 32'd0);
    check("mid_rst_dmem3", dut.dmem[3], 32'h55);
    check("mid_rst_dmem2_old", dut.dmem[2], 32'h1234);
    @(negedge clk);
    rst_n = 1'b1;
    x_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if ($isunknown(dut.pc)) x_cnt++;
    end
    check("restart_pc_x_cycles", x_cnt, 32'd0);
    check("restart_pc_loop", dut.pc, 32'h0C);
    check("restart_r2", dut.rf.regs[2], 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
